// File: rtl/frame_ctrl.sv
// APU frame sequencer control: $4017 mode/mask, parity-dependent delayed
// step-counter reset, quarter/half-frame clock gating and frame IRQ flag.
module frame_ctrl #(
  parameter int unsigned DLY_EVEN = 3,
  parameter int unsigned DLY_ODD  = 4
) (
  input  logic       CLK,
  input  logic       RES,
  input  logic       PHI_EN,
  input  logic       W4017,
  input  logic       R4015,
  input  logic [1:0] DIN,
  input  logic       STEP_Q,
  input  logic       STEP_H,
  input  logic       STEP_IRQ,
  input  logic       STEP_END,
  output logic       MODE,
  output logic       LFSR_RST,
  output logic       Q_CLK,
  output logic       H_CLK,
  output logic       INT_FLAG,
  output logic       n_INT
);

  localparam int unsigned CNT_W = 3;

  typedef enum logic {
    IDLE,
    WAIT
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               odd_q, odd_d;
  logic               mode_q, mode_d;
  logic               mask_q, mask_d;
  logic               flag_q, flag_d;
  logic               lfsr_rst_q, lfsr_rst_d;
  logic               q_clk_q, q_clk_d;
  logic               h_clk_q, h_clk_d;
  logic               fire_c;
  logic [CNT_W-1:0]   load_c;

  // Delay to load on a write depends on the APU phase seen at that edge
  assign load_c = odd_q ? CNT_W'(DLY_ODD) : CNT_W'(DLY_EVEN);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    odd_d      = odd_q;
    mode_d     = mode_q;
    mask_d     = mask_q;
    flag_d     = flag_q;
    lfsr_rst_d = lfsr_rst_q;
    q_clk_d    = q_clk_q;
    h_clk_d    = h_clk_q;
    fire_c     = 1'b0;

    if (PHI_EN) begin
      odd_d = ~odd_q;

      case (state_q)
        IDLE: begin
          if (W4017) begin
            state_d = WAIT;
            cnt_d   = load_c;
          end
        end
        WAIT: begin
          if (W4017) begin
            cnt_d = load_c;
          end else if (cnt_q == CNT_W'(1)) begin
            fire_c  = 1'b1;
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase

      // Delayed reset in 5-step mode also issues an immediate frame clock
      lfsr_rst_d = fire_c | STEP_END;
      q_clk_d    = STEP_Q | (fire_c & mode_q);
      h_clk_d    = STEP_H | (fire_c & mode_q);

      // Inhibit write wins over a set; a set wins over a $4015 read clear
      if (W4017 && DIN[0]) begin
        flag_d = 1'b0;
      end else if (STEP_IRQ && !mode_q && !mask_q) begin
        flag_d = 1'b1;
      end else if (R4015) begin
        flag_d = 1'b0;
      end

      if (W4017) begin
        mode_d = DIN[1];
        mask_d = DIN[0];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RES) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      odd_q      <= 1'b0;
      mode_q     <= 1'b0;
      mask_q     <= 1'b0;
      flag_q     <= 1'b0;
      lfsr_rst_q <= 1'b1;
      q_clk_q    <= 1'b0;
      h_clk_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      odd_q      <= odd_d;
      mode_q     <= mode_d;
      mask_q     <= mask_d;
      flag_q     <= flag_d;
      lfsr_rst_q <= lfsr_rst_d;
      q_clk_q    <= q_clk_d;
      h_clk_q    <= h_clk_d;
    end
  end

  assign MODE     = mode_q;
  assign LFSR_RST = lfsr_rst_q;
  assign Q_CLK    = q_clk_q;
  assign H_CLK    = h_clk_q;
  assign INT_FLAG = flag_q;
  assign n_INT    = ~flag_q;

endmodule

// File: tb/tb_frame_ctrl.sv
// Scoreboard bench for frame_ctrl: a time-based reference model schedules
// the delayed reset by absolute CPU-edge number and queues expected outputs.
module tb_frame_ctrl;

  localparam int unsigned DLY_EVEN = 3;
  localparam int unsigned DLY_ODD  = 4;

  logic       clk = 1'b0;
  logic       res, phi_en, w4017, r4015;
  logic [1:0] din;
  logic       step_q, step_h, step_irq, step_end;
  logic       mode, lfsr_rst, q_clk, h_clk, int_flag, n_int;

  frame_ctrl #(.DLY_EVEN(DLY_EVEN), .DLY_ODD(DLY_ODD)) dut (
    .CLK      (clk),
    .RES      (res),
    .PHI_EN   (phi_en),
    .W4017    (w4017),
    .R4015    (r4015),
    .DIN      (din),
    .STEP_Q   (step_q),
    .STEP_H   (step_h),
    .STEP_IRQ (step_irq),
    .STEP_END (step_end),
    .MODE     (mode),
    .LFSR_RST (lfsr_rst),
    .Q_CLK    (q_clk),
    .H_CLK    (h_clk),
    .INT_FLAG (int_flag),
    .n_INT    (n_int)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit lfsr;
    bit q;
    bit h;
    bit mode;
    bit flag;
  } exp_t;

  exp_t expq[$];
  exp_t last_exp = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

  // Reference model state: reset is scheduled as an absolute edge number
  bit m_mode = 1'b0, m_mask = 1'b0, m_flag = 1'b0, m_odd = 1'b0;
  int m_k = 0;
  int m_due = -1;

  int n_checks = 0;
  int n_fail = 0;
  bit stim_done = 1'b0;

  task automatic chk(input string name, input bit act, input bit exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b at t=%0t", name, act, exp_v, $time);
    end
  endtask

  // One clock: drive inputs, advance the model, queue the expected outputs
  task automatic cyc(input bit r_es, input bit phi, input bit w, input bit r,
                     input bit [1:0] d, input bit sq, input bit sh,
                     input bit sirq, input bit send);
    exp_t e;
    bit fire;
    res = r_es; phi_en = phi; w4017 = w; r4015 = r; din = d;
    step_q = sq; step_h = sh; step_irq = sirq; step_end = send;
    e = last_exp;
    if (r_es) begin
      m_mode = 1'b0; m_mask = 1'b0; m_flag = 1'b0; m_odd = 1'b0; m_due = -1;
      e = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    end else if (phi) begin
      m_k++;
      fire = (m_due == m_k) && !w;
      e.lfsr = fire | send;
      e.q = sq | (fire & m_mode);
      e.h = sh | (fire & m_mode);
      if (w && d[0]) m_flag = 1'b0;
      else if (sirq && !m_mode && !m_mask) m_flag = 1'b1;
      else if (r) m_flag = 1'b0;
      if (w) begin
        m_mode = d[1];
        m_mask = d[0];
        m_due = m_k + (m_odd ? int'(DLY_ODD) : int'(DLY_EVEN));
      end
      if (fire) m_due = -1;
      m_odd = !m_odd;
      e.mode = m_mode;
      e.flag = m_flag;
    end
    last_exp = e;
    expq.push_back(e);
    @(negedge clk);
  endtask

  // One CPU cycle: a few disabled clocks carrying junk strobes, then the enabled one
  task automatic cpu(input bit w, input bit r, input bit [1:0] d, input bit sq,
                     input bit sh, input bit sirq, input bit send);
    int gaps = $urandom_range(0, 2);
    for (int i = 0; i < gaps; i++)
      cyc(1'b0, 1'b0, 1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom),
          1'($urandom), 1'($urandom), 1'($urandom));
    cyc(1'b0, 1'b1, w, r, d, sq, sh, sirq, send);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cpu(0, 0, 2'b00, 0, 0, 0, 0);
  endtask

  task automatic wr(input bit [1:0] d);
    cpu(1, 0, d, 0, 0, 0, 0);
  endtask

  task automatic to_parity(input bit odd);
    if (m_odd != odd) idle(1);
  endtask

  // Monitor: every clock edge produces one queued expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() != 0) begin
        e = expq.pop_front();
        chk("lfsr_rst", lfsr_rst, e.lfsr);
        chk("q_clk", q_clk, e.q);
        chk("h_clk", h_clk, e.h);
        chk("mode", mode, e.mode);
        chk("int_flag", int_flag, e.flag);
        chk("n_int", n_int, !e.flag);
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    res = 1'b1; phi_en = 1'b0; w4017 = 1'b0; r4015 = 1'b0; din = 2'b00;
    step_q = 1'b0; step_h = 1'b0; step_irq = 1'b0; step_end = 1'b0;
    @(negedge clk);

    // Reset held across enabled and disabled clocks, with strobes active
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 1, 1, 2'b11, 1, 1, 1, 1);
      cyc(1, 1, 1, 1, 2'b11, 1, 1, 1, 1);
    end
    idle(4);

    // Even-phase $00 write, then separate odd-phase $80 write
    to_parity(0); wr(2'b00); idle(6);
    to_parity(1); wr(2'b10); idle(7);
    to_parity(0); wr(2'b00); idle(5);

    // Frame IRQ: set, read clear, set+read together
    cpu(0, 0, 2'b00, 0, 0, 1, 0); idle(3);
    cpu(0, 1, 2'b00, 0, 0, 0, 0); idle(2);
    cpu(0, 1, 2'b00, 0, 0, 1, 0); idle(2);

    // Inhibit write clears flag and masks later IRQs; mode 1 also masks
    wr(2'b01); idle(2);
    cpu(0, 0, 2'b00, 0, 0, 1, 0); idle(5);
    wr(2'b10); idle(6);
    cpu(0, 0, 2'b00, 0, 0, 1, 0); idle(2);
    wr(2'b00); idle(6);

    // Step clocks and sequence wrap, including wrap on the delayed-reset edge
    cpu(0, 0, 2'b00, 1, 0, 0, 0);
    cpu(0, 0, 2'b00, 0, 1, 0, 0);
    cpu(0, 0, 2'b00, 1, 1, 0, 1);
    idle(2);
    to_parity(0); wr(2'b00); idle(2);
    cpu(0, 0, 2'b00, 0, 0, 0, 1); idle(3);

    // Restart while pending: single reset from the second write's parity
    to_parity(0); wr(2'b00); idle(1); wr(2'b00); idle(7);

    // Reset mid-delay cancels the pending reset
    to_parity(0); wr(2'b10);
    cyc(1, 1, 0, 0, 2'b00, 0, 0, 0, 0);
    idle(8);

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 63) == 0) begin
        cyc(1, 1'($urandom), 0, 0, 2'b00, 0, 0, 0, 0);
      end else begin
        cpu($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, 2'($urandom),
            $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
            $urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0);
      end
    end

    stim_done = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (expq.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", expq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
